fifo_destino: RTL and testbench



---
 rtl/fifo_destino_pkg.sv | 27 ++
 rtl/fifo_destino_if.sv | 30 +++
 rtl/fifo_destino_mem_fifo.sv | 24 ++
 rtl/fifo_destino.sv | 90 +++++++++
 tb/tb_fifo_destino.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/fifo_destino_pkg.sv
// Shared constants for the destination FIFO: default widths/thresholds,
// depth derivation and the word-field layout used across the transmission layer.
package fifo_destino_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int ADDR_W_DEF = 2;
  localparam int AF_TH_DEF  = 3;
  localparam int AE_TH_DEF  = 1;

  // Word layout: [5:4] class, [3] destination, [2:0] payload
  localparam int CLASS_MSB = 5;
  localparam int CLASS_LSB = 4;
  localparam int DEST_BIT  = 3;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic logic [1:0] word_class(input logic [DATA_W_DEF-1:0] w);
    return w[CLASS_MSB:CLASS_LSB];
  endfunction

  function automatic logic word_dest(input logic [DATA_W_DEF-1:0] w);
    return w[DEST_BIT];
  endfunction

endpackage

// File: rtl/fifo_destino_if.sv
// Handshake/status bundle between the arbiter/consumer (master) and the
// destination FIFO (slave).
interface fifo_destino_if #(
  parameter int DATA_W = fifo_destino_pkg::DATA_W_DEF,
  parameter int ADDR_W = fifo_destino_pkg::ADDR_W_DEF
);
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   fill_count;
  logic              error_out;

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           fill_count, error_out
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           fill_count, error_out
  );
endinterface

// File: rtl/fifo_destino_mem_fifo.sv
// Storage array for the destination FIFO: one synchronous write port,
// one asynchronous read port, no reset on the array.
module mem_fifo #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read is combinational so a pop and a push to the same slot return the old word
  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_destino.sv
// Destination-side FIFO with registered read and almost_full back-pressure.
// Optional sticky overflow/underflow flag: define FIFO_DESTINO_ERROR_EN.
module fifo_destino
  import fifo_destino_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int AF_TH  = AF_TH_DEF,
  parameter int AE_TH  = AE_TH_DEF
) (
  input  logic           clk,
  input  logic           reset_L,
  fifo_destino_if.slave  bus
);

  localparam int              DEPTH   = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] rdata;
  logic              push_acc;
  logic              pop_acc;

  assign bus.full         = (count == DEPTH_C);
  assign bus.empty        = (count == '0);
  assign bus.almost_full  = (count >= AF_C);
  assign bus.almost_empty = (count <= AE_C);
  assign bus.fill_count   = count;

  // A push into a full FIFO is still taken when a pop frees the oldest slot
  assign push_acc = bus.push && (!bus.full || bus.pop);
  assign pop_acc  = bus.pop && !bus.empty;

  mem_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc) begin
        rd_ptr       <= rd_ptr + PTR_ONE;
        bus.data_out <= rdata;
      end
      bus.valid_out <= pop_acc;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

`ifdef FIFO_DESTINO_ERROR_EN
  logic error_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      error_q <= 1'b0;
    end else if ((bus.push && !push_acc) || (bus.pop && !pop_acc)) begin
      error_q <= 1'b1;
    end
  end

  assign bus.error_out = error_q;
`else
  assign bus.error_out = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_destino.sv
// Scoreboard bench for fifo_destino: queue reference model, expected reads
// queued at issue time and checked by a negedge monitor.
module tb_fifo_destino;
  import fifo_destino_pkg::*;

  localparam int DEPTH = 4;
`ifdef FIFO_DESTINO_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_L = 1'b0;

  fifo_destino_if bus();

  fifo_destino dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [5:0] mq[$];
  logic [5:0] exp_q[$];
  bit         exp_valid;
  logic [5:0] last_data;
  bit         exp_err;
  logic [5:0] e;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    exp_valid = 1'b0;
    last_data = '0;
    exp_err   = 1'b0;
  endtask

  task automatic model_step(input bit p, input logic [5:0] d, input bit q);
    bit full_m, empty_m, push_ok, pop_ok;
    logic [5:0] w;
    full_m  = (mq.size() == DEPTH);
    empty_m = (mq.size() == 0);
    pop_ok  = q && !empty_m;
    push_ok = p && (!full_m || q);
    if (pop_ok) begin
      w = mq.pop_front();
      exp_q.push_back(w);
      last_data = w;
    end
    if (push_ok) mq.push_back(d);
    exp_valid = pop_ok;
    if (ERR_EN && ((p && !push_ok) || (q && !pop_ok))) exp_err = 1'b1;
  endtask

  task automatic cycle(input bit p, input logic [5:0] d, input bit q);
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = q;
    @(posedge clk);
    #1;
    model_step(p, d, q);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("valid_out", int'(bus.valid_out), int'(exp_valid));
    if (bus.valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underrun: got valid word %0d want no read pending", bus.data_out);
      end else begin
        e = exp_q.pop_front();
        chk("data_out", int'(bus.data_out), int'(e));
      end
    end else begin
      chk("data_hold", int'(bus.data_out), int'(last_data));
    end
    chk("fill_count",   int'(bus.fill_count),   mq.size());
    chk("full",         int'(bus.full),         int'(mq.size() == DEPTH));
    chk("empty",        int'(bus.empty),        int'(mq.size() == 0));
    chk("almost_full",  int'(bus.almost_full),  int'(mq.size() >= AF_TH_DEF));
    chk("almost_empty", int'(bus.almost_empty), int'(mq.size() <= AE_TH_DEF));
    chk("error_out",    int'(bus.error_out),    int'(exp_err));
  end

  initial begin
    model_reset();
    bus.push    = 1'b1;
    bus.data_in = 6'h3f;
    bus.pop     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_L  = 1'b1;
    bus.push = 1'b0;

    // fill, overflow, drain, underflow
    cycle(1'b1, 6'b110100, 1'b0);
    cycle(1'b1, 6'b100101, 1'b0);
    cycle(1'b1, 6'b110110, 1'b0);
    cycle(1'b1, 6'b111101, 1'b0);
    cycle(1'b1, 6'b010110, 1'b0);
    repeat (4) cycle(1'b0, 6'h00, 1'b1);
    cycle(1'b0, 6'h00, 1'b0);
    cycle(1'b0, 6'h00, 1'b1);
    cycle(1'b0, 6'h00, 1'b0);

    // reset mid-stream: outputs must clear without waiting for a clock
    cycle(1'b1, 6'h2a, 1'b0);
    cycle(1'b1, 6'h15, 1'b1);
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    chk("rst_fill_count", int'(bus.fill_count), 0);
    chk("rst_empty",      int'(bus.empty),      1);
    chk("rst_valid_out",  int'(bus.valid_out),  0);
    chk("rst_data_out",   int'(bus.data_out),   0);
    chk("rst_error_out",  int'(bus.error_out),  0);
    bus.push    = 1'b1;
    bus.data_in = 6'h3c;
    @(posedge clk);
    #1;
    reset_L  = 1'b1;
    bus.push = 1'b0;

    // steady push+pop at count 2, then push+pop while full
    cycle(1'b1, 6'($urandom), 1'b0);
    cycle(1'b1, 6'($urandom), 1'b0);
    repeat (8) cycle(1'b1, 6'($urandom), 1'b1);
    cycle(1'b1, 6'($urandom), 1'b0);
    cycle(1'b1, 6'($urandom), 1'b0);
    repeat (2) cycle(1'b1, 6'($urandom), 1'b1);
    repeat (4) cycle(1'b0, 6'h00, 1'b1);

    // push+pop on empty: no fall-through
    cycle(1'b1, 6'b101100, 1'b1);
    cycle(1'b0, 6'h00, 1'b1);
    cycle(1'b0, 6'h00, 1'b0);

    // random traffic, push-heavy then pop-heavy
    repeat (200) cycle(($urandom_range(0, 99) < 65), 6'($urandom), ($urandom_range(0, 99) < 40));
    repeat (200) cycle(($urandom_range(0, 99) < 40), 6'($urandom), ($urandom_range(0, 99) < 65));

    repeat (5) cycle(1'b0, 6'h00, 1'b1);
    cycle(1'b0, 6'h00, 1'b0);
    @(negedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
